dram_arbiter: RTL and testbench

Shares the single DRAM port between the L1 instruction-cache controller and the L1 data-cache controller.
- Accepts level-held requests from both sides.
- Grants one requester at a time, round-robin on ties.
- Forwards the granted transaction to DRAM and returns read data with a one-cycle ack pulse.
- A watchdog aborts transactions whose DRAM ack never arrives.

---
 rtl/dram_arbiter_pkg.sv | 17 +
 rtl/dram_arbiter_rr_pick2.sv | 30 +++
 rtl/dram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DRAM arbiter.
// Contents:
//   arb_state_t  - arbiter FSM states
//   REQ_I/REQ_D  - requester IDs used for grant tracking
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_XFER_I = 2'd1,
    ARB_XFER_D = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/dram_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector.
// Ports:
//   req_i, req_d  - request lines from the I-side and D-side
//   last_grant    - requester ID that won most recently
//   gnt_valid     - at least one request is present
//   gnt_id        - winning requester ID (REQ_I / REQ_D)
module rr_pick2
  import dram_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // A lone requester always wins; on a tie the side that did not win
  // last time goes next, which makes grants alternate under contention.
  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) begin
      gnt_id = ~last_grant;
    end else if (req_d) begin
      gnt_id = REQ_D;
    end else begin
      gnt_id = REQ_I;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates the single DRAM port between the I-cache and D-cache
// controllers, with a watchdog that aborts transactions DRAM never acks.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   i_cs/i_we/i_addr/i_wdata    - I-cache request (cs held until i_ack)
//   i_rdata/i_ack               - I-cache read data and completion pulse
//   d_*                         - same set for the D-cache
//   mem_cs/mem_we/mem_addr/
//   mem_wdata                   - DRAM request, held until mem_ack
//   mem_rdata/mem_ack           - DRAM read data and completion pulse
//   busy                        - arbiter not idle
//   timeout_err                 - sticky watchdog abort flag
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cs,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_cs,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          timeout_err
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  arb_state_t    state, state_next;
  logic          last_grant, last_grant_next;
  logic [WW-1:0] wdog, wdog_next;
  logic          gnt_valid, gnt_id;
  logic          in_xfer, xfer_d, wdog_expired;

  logic [DW-1:0] i_rdata_next, d_rdata_next;
  logic          i_ack_next, d_ack_next;
  logic          mem_cs_next, mem_we_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wdata_next;
  logic          busy_next, timeout_err_next;

  rr_pick2 u_pick (
    .req_i      (i_cs),
    .req_d      (d_cs),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign in_xfer      = (state == ARB_XFER_I) || (state == ARB_XFER_D);
  assign xfer_d       = (state == ARB_XFER_D);
  assign wdog_expired = (wdog == WDOG_LAST);

  // State register; every output is registered here as well so the
  // reset clears the whole visible interface in one place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      last_grant  <= REQ_I;
      wdog        <= '0;
      i_rdata     <= '0;
      i_ack       <= 1'b0;
      d_rdata     <= '0;
      d_ack       <= 1'b0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      last_grant  <= last_grant_next;
      wdog        <= wdog_next;
      i_rdata     <= i_rdata_next;
      i_ack       <= i_ack_next;
      d_rdata     <= d_rdata_next;
      d_ack       <= d_ack_next;
      mem_cs      <= mem_cs_next;
      mem_we      <= mem_we_next;
      mem_addr    <= mem_addr_next;
      mem_wdata   <= mem_wdata_next;
      busy        <= busy_next;
      timeout_err <= timeout_err_next;
    end
  end

  // Next-state logic. An ack arriving together with watchdog expiry
  // still ends the transfer here; the output logic decides it is a
  // normal completion.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (gnt_valid) begin
          state_next = (gnt_id == REQ_D) ? ARB_XFER_D : ARB_XFER_I;
        end
      end
      ARB_XFER_I, ARB_XFER_D: begin
        if (mem_ack || wdog_expired) begin
          state_next = ARB_DONE;
        end
      end
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Next values for the registered outputs. Request inputs are only
  // looked at in IDLE, which is what freezes mem_* during a transfer.
  always_comb begin
    last_grant_next  = last_grant;
    wdog_next        = wdog;
    i_rdata_next     = i_rdata;
    d_rdata_next     = d_rdata;
    i_ack_next       = 1'b0;
    d_ack_next       = 1'b0;
    mem_cs_next      = mem_cs;
    mem_we_next      = mem_we;
    mem_addr_next    = mem_addr;
    mem_wdata_next   = mem_wdata;
    timeout_err_next = timeout_err;
    busy_next        = (state_next != ARB_IDLE);

    if (state == ARB_IDLE && gnt_valid) begin
      last_grant_next = gnt_id;
      wdog_next       = '0;
      mem_cs_next     = 1'b1;
      mem_we_next     = (gnt_id == REQ_D) ? d_we    : i_we;
      mem_addr_next   = (gnt_id == REQ_D) ? d_addr  : i_addr;
      mem_wdata_next  = (gnt_id == REQ_D) ? d_wdata : i_wdata;
    end else if (in_xfer) begin
      if (mem_ack) begin
        mem_cs_next = 1'b0;
        mem_we_next = 1'b0;
        if (xfer_d) begin
          d_rdata_next = mem_rdata;
          d_ack_next   = 1'b1;
        end else begin
          i_rdata_next = mem_rdata;
          i_ack_next   = 1'b1;
        end
      end else if (wdog_expired) begin
        mem_cs_next      = 1'b0;
        timeout_err_next = 1'b1;
        if (xfer_d) begin
          d_rdata_next = '0;
          d_ack_next   = 1'b1;
        end else begin
          i_rdata_next = '0;
          i_ack_next   = 1'b1;
        end
      end else begin
        wdog_next = wdog + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter: directed scenarios with literal
// expectations plus a randomized run, all continuously compared against
// a transaction-level model of the arbiter.
module tb_dram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic i_cs, i_we, d_cs, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic i_ack, d_ack, mem_cs, mem_we, busy, timeout_err;

  int testsRun  = 0;
  int failCount = 0;
  bit checkOn   = 1'b0;

  always #5 clk = ~clk;

  dram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ack(i_ack),
    .d_cs(d_cs), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: one transfer in flight at most, followed by
  // a single turnaround cycle before the next grant.
  bit mActive, mGap;
  int mWho, mAge, mLast;
  logic eMemCs, eMemWe, eIAck, eDAck, eBusy, eErr;
  logic [31:0] eMemAddr, eMemWdata, eIRdata, eDRdata;

  task automatic modelReset();
    mActive = 0; mGap = 0; mWho = 0; mAge = 0; mLast = 0;
    eMemCs = 0; eMemWe = 0; eIAck = 0; eDAck = 0; eBusy = 0; eErr = 0;
    eMemAddr = 0; eMemWdata = 0; eIRdata = 0; eDRdata = 0;
  endtask

  task automatic modelComplete(input logic [31:0] data, input bit err);
    mActive = 0;
    mGap    = 1;
    eMemCs  = 0;
    if (mWho == 0) begin eIAck = 1; eIRdata = data; end
    else begin eDAck = 1; eDRdata = data; end
    if (err) eErr = 1;
  endtask

  task automatic modelStep();
    eIAck = 0;
    eDAck = 0;
    if (mActive) begin
      if (mem_ack) begin
        modelComplete(mem_rdata, 0);
        eMemWe = 0;
      end else if (mAge == TO - 1) begin
        modelComplete(32'd0, 1);
      end else begin
        mAge++;
      end
    end else if (mGap) begin
      mGap = 0;
    end else if (i_cs || d_cs) begin
      if (i_cs && d_cs) mWho = 1 - mLast;
      else mWho = d_cs ? 1 : 0;
      mLast     = mWho;
      mActive   = 1;
      mAge      = 0;
      eMemCs    = 1;
      eMemWe    = (mWho == 1) ? d_we    : i_we;
      eMemAddr  = (mWho == 1) ? d_addr  : i_addr;
      eMemWdata = (mWho == 1) ? d_wdata : i_wdata;
    end
    eBusy = mActive || mGap;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) modelReset();
    else modelStep();
  end

  // Compare process: DUT outputs against the model every cycle.
  initial forever begin
    @(negedge clk);
    if (checkOn && !rst) begin
      checkOutput("mem_cs", 32'(mem_cs), 32'(eMemCs));
      checkOutput("i_ack", 32'(i_ack), 32'(eIAck));
      checkOutput("d_ack", 32'(d_ack), 32'(eDAck));
      checkOutput("i_rdata", i_rdata, eIRdata);
      checkOutput("d_rdata", d_rdata, eDRdata);
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("timeout_err", 32'(timeout_err), 32'(eErr));
      if (eMemCs) begin
        checkOutput("mem_we", 32'(mem_we), 32'(eMemWe));
        checkOutput("mem_addr", mem_addr, eMemAddr);
        checkOutput("mem_wdata", mem_wdata, eMemWdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitMemCs(input string name);
    int n = 0;
    while (!mem_cs && n < 50) begin
      tick();
      n++;
    end
    if (!mem_cs) checkOutput(name, 32'd0, 32'd1);
  endtask

  task automatic doReset();
    tick();
    #2 rst = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input int cycles);
    int waitCnt = 0;
    int target  = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (i_ack) i_cs = 1'b0;
      else if (i_cs) begin if ($urandom_range(0, 15) == 0) i_cs = 1'b0; end
      else i_cs = ($urandom_range(0, 2) == 0);
      if (d_ack) d_cs = 1'b0;
      else if (d_cs) begin if ($urandom_range(0, 15) == 0) d_cs = 1'b0; end
      else d_cs = ($urandom_range(0, 2) == 0);
      i_we = 1'($urandom_range(0, 1));
      d_we = 1'($urandom_range(0, 1));
      i_addr = $urandom; d_addr = $urandom;
      i_wdata = $urandom; d_wdata = $urandom;
      mem_rdata = $urandom;
      if (mem_cs) begin
        mem_ack = (waitCnt == target);
        waitCnt++;
      end else begin
        waitCnt = 0;
        target  = $urandom_range(0, TO + 1);
        mem_ack = ($urandom_range(0, 7) == 0);
      end
    end
    tick();
    i_cs = 0; d_cs = 0; mem_ack = 0;
    repeat (TO + 4) tick();
  endtask

  initial begin
    logic [31:0] expAddr [4];
    int n;
    expAddr = '{32'h20, 32'h10, 32'h20, 32'h10};
    rst = 1'b1;
    i_cs = 0; i_we = 0; i_addr = 0; i_wdata = 0;
    d_cs = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    tick();
    tick();

    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mem_cs", 32'(mem_cs), 32'd0);
    checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("reset i_rdata", i_rdata, 32'd0);
    checkOutput("reset d_ack", 32'(d_ack), 32'd0);
    #2 rst = 1'b0;
    checkOn = 1'b1;
    tick();

    // Single D-side read, DRAM answers three cycles after mem_cs rises.
    d_cs = 1; d_we = 0; d_addr = 32'h100;
    waitMemCs("single grant");
    checkOutput("single mem_addr", mem_addr, 32'h100);
    checkOutput("single mem_we", 32'(mem_we), 32'd0);
    tick();
    tick();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0;
    checkOutput("single d_ack", 32'(d_ack), 32'd1);
    checkOutput("single d_rdata", d_rdata, 32'hDEADBEEF);
    checkOutput("single mem_cs low", 32'(mem_cs), 32'd0);
    d_cs = 0;
    tick();
    checkOutput("single d_ack one cycle", 32'(d_ack), 32'd0);

    // Both sides held from reset: D wins first, then alternation.
    doReset();
    i_cs = 1; d_cs = 1; i_addr = 32'h10; d_addr = 32'h20; i_we = 0; d_we = 0;
    for (int k = 0; k < 4; k++) begin
      waitMemCs("rr grant");
      checkOutput($sformatf("rr addr %0d", k), mem_addr, expAddr[k]);
      mem_ack = 1;
      tick();
      mem_ack = 0;
      if (k < 3) begin
        n = 0;
        while (!mem_cs && n < 10) begin
          n++;
          tick();
        end
        checkOutput("rr gap cycles", 32'(n), 32'd2);
      end
    end
    i_cs = 0; d_cs = 0;
    tick();
    tick();

    // Write forwarding; changes to i_wdata mid-transfer must not leak.
    i_cs = 1; i_we = 1; i_addr = 32'h40; i_wdata = 32'h12345678;
    waitMemCs("write grant");
    checkOutput("write mem_we", 32'(mem_we), 32'd1);
    checkOutput("write mem_wdata", mem_wdata, 32'h12345678);
    i_wdata = 32'h0;
    tick();
    checkOutput("write wdata held", mem_wdata, 32'h12345678);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    checkOutput("write i_ack", 32'(i_ack), 32'd1);
    i_cs = 0; i_we = 0;
    tick();
    tick();

    // Watchdog abort, then a normal I-side transfer afterwards.
    d_cs = 1; d_addr = 32'h200;
    waitMemCs("timeout grant");
    n = 0;
    while (!d_ack && n < 20) begin
      tick();
      n++;
    end
    checkOutput("timeout latency", 32'(n), 32'd8);
    checkOutput("timeout d_rdata", d_rdata, 32'd0);
    checkOutput("timeout err set", 32'(timeout_err), 32'd1);
    d_cs = 0;
    tick();
    i_cs = 1; i_addr = 32'h44;
    waitMemCs("post-timeout grant");
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    checkOutput("post-timeout i_rdata", i_rdata, 32'hCAFEF00D);
    checkOutput("timeout err sticky", 32'(timeout_err), 32'd1);
    i_cs = 0;
    tick();
    tick();

    // Ack arriving in the same cycle the watchdog expires wins.
    doReset();
    checkOutput("err cleared by reset", 32'(timeout_err), 32'd0);
    d_cs = 1; d_addr = 32'h300;
    waitMemCs("coincide grant");
    repeat (TO - 1) tick();
    mem_ack = 1; mem_rdata = 32'h0BADC0DE;
    tick();
    mem_ack = 0;
    checkOutput("coincide d_ack", 32'(d_ack), 32'd1);
    checkOutput("coincide d_rdata", d_rdata, 32'h0BADC0DE);
    checkOutput("coincide no err", 32'(timeout_err), 32'd0);
    d_cs = 0;
    tick();
    tick();

    // Reset in the middle of a D-side transfer.
    d_cs = 1; d_addr = 32'h400;
    waitMemCs("midreset grant");
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset mem_cs", 32'(mem_cs), 32'd0);
    checkOutput("midreset d_ack", 32'(d_ack), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    d_cs = 0;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    checkOutput("post-reset busy", 32'(busy), 32'd0);
    checkOutput("post-reset err", 32'(timeout_err), 32'd0);

    applyStimulus(4000);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
